// File: rtl/uart_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_responder
// Purpose  : Host-side command responder. Pops register read/write frames
//            (OP, ADDR, [DATA], [CSUM]) from the UART RX FIFO, executes them
//            against an internal 8-bit register file and pushes exactly one
//            response byte per frame into the UART TX FIFO.
// Options  : UART_REG_RESPONDER_CSUM_EN - every frame carries a trailing XOR
//            checksum byte that must match before the frame is executed.
// Revision : 1.0 - initial release
// ============================================================================
module uart_reg_responder #(
  parameter int         NumRegs       = 16,
  parameter int         TimeoutCycles = 50000,
  parameter logic [7:0] AckByte       = 8'h06,
  parameter logic [7:0] NakByte       = 8'h15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_rdy,
  input  logic [7:0]           i_rx_data,
  output logic                 o_rx_req,
  input  logic                 i_tx_rdy,
  output logic                 o_tx_req,
  output logic [7:0]           o_tx_data,
  output logic [NumRegs*8-1:0] o_regs,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int         AddrWidth  = $clog2(NumRegs);
  localparam int         TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [8:0] NUM_REGS_9 = 9'(NumRegs);

`ifdef UART_REG_RESPONDER_CSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_GET_CSUM = 3'd3,
    ST_EXEC     = 3'd4,
    ST_SEND     = 3'd5
  } state_e;
  // Once the payload is in, the checksum byte still has to be collected
  localparam state_e ST_PAYLOAD_DONE = ST_GET_CSUM;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_EXEC     = 3'd4,
    ST_SEND     = 3'd5
  } state_e;
  localparam state_e ST_PAYLOAD_DONE = ST_EXEC;
`endif

  state_e               state;
  state_e               state_next;
  logic                 pop_gap;      // a byte was popped last cycle
  logic                 pop_ok;
  logic                 op_valid;
  logic                 timer_done;
  logic                 timeout_hit;
  logic                 is_write;
  logic [7:0]           addr;
  logic [7:0]           data;
  logic [7:0]           resp;
  logic                 resp_nak;
  logic                 addr_ok;
  logic                 csum_ok;
  logic                 frame_ok;
  logic [AddrWidth-1:0] addr_idx;
  logic [7:0]           regs [NumRegs];

  // The FIFO needs one idle cycle between pops to advance its head
  assign pop_ok   = i_rx_rdy && !pop_gap;
  assign op_valid = (i_rx_data == OP_WRITE) || (i_rx_data == OP_READ);
  assign addr_idx = addr[AddrWidth-1:0];
  assign addr_ok  = {1'b0, addr} < NUM_REGS_9;
  assign frame_ok = addr_ok && csum_ok;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode; strobes are held off while reset is asserted
  always_comb begin
    state_next  = state;
    o_rx_req    = 1'b0;
    o_tx_req    = 1'b0;
    timeout_hit = 1'b0;
    if (i_rst_n) begin
      case (state)
        ST_IDLE: begin
          if (pop_ok) begin
            o_rx_req   = 1'b1;
            state_next = op_valid ? ST_GET_ADDR : ST_SEND;
          end
        end
        ST_GET_ADDR: begin
          if (pop_ok) begin
            o_rx_req   = 1'b1;
            state_next = is_write ? ST_GET_DATA : ST_PAYLOAD_DONE;
          end else if (timer_done) begin
            timeout_hit = 1'b1;
            state_next  = ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (pop_ok) begin
            o_rx_req   = 1'b1;
            state_next = ST_PAYLOAD_DONE;
          end else if (timer_done) begin
            timeout_hit = 1'b1;
            state_next  = ST_IDLE;
          end
        end
`ifdef UART_REG_RESPONDER_CSUM_EN
        ST_GET_CSUM: begin
          if (pop_ok) begin
            o_rx_req   = 1'b1;
            state_next = ST_EXEC;
          end else if (timer_done) begin
            timeout_hit = 1'b1;
            state_next  = ST_IDLE;
          end
        end
`endif
        ST_EXEC: begin
          state_next = ST_SEND;
        end
        ST_SEND: begin
          if (i_tx_rdy) begin
            o_tx_req   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  generate
    if (TimeoutCycles > 0) begin : g_timeout
      logic                  waiting;
      logic [TimerWidth-1:0] timer;

`ifdef UART_REG_RESPONDER_CSUM_EN
      assign waiting = (state == ST_GET_ADDR) || (state == ST_GET_DATA) ||
                       (state == ST_GET_CSUM);
`else
      assign waiting = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
`endif
      // Timer value k-1 in the k-th cycle after the last consumed byte
      assign timer_done = (timer == TimerWidth'(TimeoutCycles - 1));

      // Inter-byte timer: restarts on every consumed byte, runs only mid-frame
      always_ff @(posedge i_clk) begin
        if (!i_rst_n || o_rx_req || !waiting || timeout_hit) begin
          timer <= '0;
        end else begin
          timer <= timer + TimerWidth'(1);
        end
      end
    end else begin : g_no_timeout
      assign timer_done = 1'b0;
    end
  endgenerate

`ifdef UART_REG_RESPONDER_CSUM_EN
  logic [7:0] csum_acc;

  // XOR of every frame byte including CSUM; a good frame folds to zero
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      csum_acc <= 8'h00;
    end else if (o_rx_req) begin
      csum_acc <= (state == ST_IDLE) ? i_rx_data : (csum_acc ^ i_rx_data);
    end
  end

  assign csum_ok = (csum_acc == 8'h00);
`else
  assign csum_ok = 1'b1;
`endif

  // Frame field capture and response byte generation
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pop_gap  <= 1'b0;
      is_write <= 1'b0;
      addr     <= 8'h00;
      data     <= 8'h00;
      resp     <= 8'h00;
      resp_nak <= 1'b0;
    end else begin
      pop_gap <= o_rx_req;
      if (o_rx_req) begin
        case (state)
          ST_IDLE: begin
            is_write <= (i_rx_data == OP_WRITE);
            if (!op_valid) begin
              resp     <= NakByte;
              resp_nak <= 1'b1;
            end
          end
          ST_GET_ADDR: addr <= i_rx_data;
          ST_GET_DATA: data <= i_rx_data;
          default: ;
        endcase
      end
      if (state == ST_EXEC) begin
        resp_nak <= !frame_ok;
        if (!frame_ok) begin
          resp <= NakByte;
        end else if (is_write) begin
          resp <= AckByte;
        end else begin
          resp <= regs[addr_idx];
        end
      end
    end
  end

  // Register file: written only by an accepted write frame
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NumRegs; k++) begin
        regs[k] <= 8'h00;
      end
    end else if ((state == ST_EXEC) && frame_ok && is_write) begin
      regs[addr_idx] <= data;
    end
  end

  generate
    for (genvar k = 0; k < NumRegs; k++) begin : g_flat
      assign o_regs[8*k +: 8] = regs[k];
    end
  endgenerate

  assign o_tx_data = resp;
  assign o_busy    = (state != ST_IDLE);
  assign o_err     = (o_tx_req && resp_nak) || timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_reg_responder
// Purpose  : Scoreboard bench for uart_reg_responder. Frames are turned into
//            expected responses by a byte-level reference model; a monitor
//            checks every TX push, error pulse and RX pop against it.
// Options  : UART_REG_RESPONDER_CSUM_EN - frames get a trailing XOR checksum
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_reg_responder;
  localparam int         NREGS = 16;
  localparam int         TMO   = 100;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
`ifdef UART_REG_RESPONDER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rx_rdy;
  logic [7:0]         rx_data;
  logic               rx_req;
  logic               tx_rdy;
  logic               tx_req;
  logic [7:0]         tx_data;
  logic [NREGS*8-1:0] regs;
  logic               busy;
  logic               err;

  uart_reg_responder #(
    .NumRegs(NREGS), .TimeoutCycles(TMO), .AckByte(ACK), .NakByte(NAK)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_rdy(rx_rdy), .i_rx_data(rx_data),
    .o_rx_req(rx_req), .i_tx_rdy(tx_rdy), .o_tx_req(tx_req),
    .o_tx_data(tx_data), .o_regs(regs), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;   // cycles from last pop to push, -1 = not checked
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] model [NREGS];
  int         tmo_pending = 0;
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         last_pop    = 0;
  bit         pop_pending = 0;
  bit         prev_rx_req = 0;
  bit         tx_random   = 0;

  // Monitor: scoreboard for TX pushes and timeouts, pop-protocol checks
  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    cyc++;
    pop_pending = rx_req && rx_rdy;
    if (rst_n) begin
      if (rx_req) begin
        vectors++;
        if (prev_rx_req || !rx_rdy) begin
          miscompares++;
          $display("FAIL pop_strobe: rx_req=1 prev_rx_req=%0b rx_rdy=%0b, required prev_rx_req=0 rx_rdy=1",
                   prev_rx_req, rx_rdy);
        end
        last_pop = cyc;
      end
      if (tx_req) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_tx: data=%h err=%0b, required no push", tx_data, err);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc - last_pop;
          if (tx_data !== e.data || err !== e.err || !tx_rdy || (e.lat >= 0 && lat != e.lat)) begin
            miscompares++;
            $display("FAIL response: data=%h err=%0b lat=%0d tx_rdy=%0b, required data=%h err=%0b lat=%0d tx_rdy=1",
                     tx_data, err, lat, tx_rdy, e.data, e.err, e.lat);
          end
        end
      end else if (err) begin
        vectors++;
        if (tmo_pending == 0) begin
          miscompares++;
          $display("FAIL unexpected_err: err=1 without push or pending timeout");
        end else begin
          tmo_pending--;
          if (cyc - last_pop != TMO) begin
            miscompares++;
            $display("FAIL timeout_latency: %0d cycles, required %0d", cyc - last_pop, TMO);
          end
        end
      end
    end
    prev_rx_req = rx_req;
  end

  // RX FIFO model (first-word-fall-through) and optional random TX backpressure
  always @(posedge clk) begin
    #1;
    if (pop_pending && rx_q.size() > 0) void'(rx_q.pop_front());
    pop_pending = 0;
    rx_rdy  = (rx_q.size() > 0);
    rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    if (tx_random) tx_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_regs(input string name);
    logic [NREGS*8-1:0] flat;
    for (int k = 0; k < NREGS; k++) flat[8*k +: 8] = model[k];
    vectors++;
    if (regs !== flat) begin
      miscompares++;
      $display("FAIL %s: o_regs=%h, required %h", name, regs, flat);
    end
  endtask

  // Reference model: frame bytes -> expected response, register update
  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] csum_mask, input bit chk_lat);
    exp_t       e;
    logic [7:0] bytes[$];
    logic [7:0] x;
    bit         valid;
    valid = (op == OP_W) || (op == OP_R);
    bytes.push_back(op);
    if (valid) begin
      bytes.push_back(a);
      if (op == OP_W) bytes.push_back(d);
      if (CSUM_ON) begin
        x = 8'h00;
        foreach (bytes[i]) x ^= bytes[i];
        bytes.push_back(x ^ csum_mask);
      end
    end
    if (!valid || a >= NREGS || (CSUM_ON && csum_mask != 8'h00)) begin
      e.data = NAK;
      e.err  = 1'b1;
    end else if (op == OP_W) begin
      model[a[3:0]] = d;
      e.data = ACK;
      e.err  = 1'b0;
    end else begin
      e.data = model[a[3:0]];
      e.err  = 1'b0;
    end
    e.lat = chk_lat ? (valid ? 2 : 1) : -1;
    exp_q.push_back(e);
    foreach (bytes[i]) rx_q.push_back(bytes[i]);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d responses and %0d bytes outstanding", exp_q.size(), rx_q.size());
    end
  endtask

  task automatic wait_rxq_le(input int n, input string name);
    int k = 0;
    while (rx_q.size() > n && k < 500) begin
      tick();
      k++;
    end
    if (k >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: %0d bytes still queued, required <= %0d", name, rx_q.size(), n);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] op, a, d, mask;
    int         kind;
    int         wlen;
    rst_n   = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    tx_rdy  = 1'b1;
    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick();

    // Reset state
    check("reset_rx_req", 32'(rx_req), 32'd0);
    check("reset_tx_req", 32'(tx_req), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check_regs("reset_regs");

    // Write then read back
    send_frame(OP_W, 8'h03, 8'hA5, 8'h00, 1'b1);
    send_frame(OP_R, 8'h03, 8'h00, 8'h00, 1'b1);
    drain();
    check("reg3_after_write", 32'(regs[31:24]), 32'hA5);

    // Out-of-range address
    send_frame(OP_W, 8'h10, 8'hFF, 8'h00, 1'b1);
    drain();
    check_regs("bad_addr_regs");

    // Unknown opcode then resync
    send_frame(8'h41, 8'h00, 8'h00, 8'h00, 1'b1);
    send_frame(OP_R, 8'h00, 8'h00, 8'h00, 1'b1);
    drain();

    // TX backpressure: no pushes and no pops while the response is held
    wlen = CSUM_ON ? 4 : 3;
    tx_rdy = 1'b0;
    send_frame(OP_R, 8'h03, 8'h00, 8'h00, 1'b0);
    send_frame(OP_W, 8'h04, 8'h11, 8'h00, 1'b1);
    wait_rxq_le(wlen, "bp_frame_consumed");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold", {30'd0, tx_req, rx_req}, 32'd0);
    end
    tx_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_push", 32'(tx_req), 32'd1);
    drain();
    check_regs("bp_regs");

    // Inter-byte timeout on a partial write
    rx_q.push_back(OP_W);
    rx_q.push_back(8'h05);
    tmo_pending++;
    tick(TMO + 15);
    check("timeout_seen", 32'(tmo_pending), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);
    send_frame(OP_R, 8'h05, 8'h00, 8'h00, 1'b1);
    drain();

    // Reset in the middle of a frame
    rx_q.push_back(OP_W);
    rx_q.push_back(8'h07);
    wait_rxq_le(0, "mid_frame_consumed");
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    tick();
    check_regs("reset_clears_regs");
    check("reset_mid_busy", 32'(busy), 32'd0);
    send_frame(OP_R, 8'h07, 8'h00, 8'h00, 1'b1);
    drain();

`ifdef UART_REG_RESPONDER_CSUM_EN
    // Checksum good (57 02 3C 69) and bad (57 02 3C 00)
    send_frame(OP_W, 8'h02, 8'h3C, 8'h00, 1'b1);
    send_frame(OP_W, 8'h02, 8'h3C, 8'h69, 1'b1);
    drain();
    check("csum_reg2_kept", 32'(regs[23:16]), 32'h3C);
`endif

    // Randomized frames with random TX backpressure
    tx_random = 1;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 99);
      a    = 8'($urandom_range(0, NREGS - 1));
      d    = 8'($urandom);
      mask = (CSUM_ON && $urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (kind < 45) begin
        send_frame(OP_W, a, d, mask, 1'b0);
      end else if (kind < 80) begin
        send_frame(OP_R, a, d, mask, 1'b0);
      end else if (kind < 90) begin
        op = 8'($urandom);
        while (op == OP_W || op == OP_R) op = 8'($urandom);
        send_frame(op, a, d, mask, 1'b0);
      end else begin
        a = 8'($urandom_range(NREGS, 255));
        send_frame((kind < 95) ? OP_W : OP_R, a, d, mask, 1'b0);
      end
      if (i % 50 == 49) begin
        drain();
        check_regs("random_regs");
      end
      if (i % 70 == 69) begin
        drain();
        rx_q.push_back(($urandom_range(0, 1) == 0) ? OP_W : OP_R);
        tmo_pending++;
        tick(TMO + 15);
        check("random_timeout_seen", 32'(tmo_pending), 32'd0);
      end
    end
    tx_random = 0;
    tx_rdy    = 1'b1;
    drain();
    check_regs("final_regs");
    check("final_outstanding", 32'(exp_q.size()) + 32'(tmo_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
